// File: rtl/mul_int64_dotacc.sv
// Dot-product accumulator behind the 64-bit multiplier: sums a packet of products
// modulo 2^WIDTH and emits one result per packet. Optional: MUL_INT64_DOTACC_OVF_EN adds out_ovf.
//
// state | meaning
// ACC   | accepting product beats into the running sum
// OUT   | holding the packet result until downstream takes it
module mul_int64_dotacc #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef MUL_INT64_DOTACC_OVF_EN
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
`else
  output logic [CNT_W-1:0] out_count
`endif
);

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] sum;
  logic             beat_acc;

`ifdef MUL_INT64_DOTACC_OVF_EN
  logic [WIDTH:0] sum_wide;
  logic           ovf_q, ovf_d;
  logic           res_ovf_q, res_ovf_d;

  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, in_data};
    sum      = sum_wide[WIDTH-1:0];
  end
`else
  always_comb begin
    sum = acc_q + in_data;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (in_valid && in_last) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // Handshake outputs are pure functions of state
  always_comb begin
    in_ready  = (state_q == S_ACC);
    out_valid = (state_q == S_OUT);
  end

  // Datapath
  always_comb begin
    beat_acc  = in_valid && in_ready;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    if (beat_acc) begin
      if (in_last) begin
        res_d     = sum;
        res_cnt_d = cnt_inc;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

`ifdef MUL_INT64_DOTACC_OVF_EN
  // Sticky carry flag for the packet in flight; the last beat's carry goes straight to the result
  always_comb begin
    ovf_d     = ovf_q;
    res_ovf_d = res_ovf_q;
    if (beat_acc) begin
      if (in_last) begin
        res_ovf_d = ovf_q | sum_wide[WIDTH];
        ovf_d     = 1'b0;
      end else begin
        ovf_d = ovf_q | sum_wide[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      res_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign out_ovf = res_ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign out_data  = res_q;
  assign out_count = res_cnt_q;

endmodule

// File: tb/tb_mul_int64_dotacc.sv
// Self-checking bench for mul_int64_dotacc: directed packets plus randomized traffic
// compared against a packet-level arithmetic model.
module tb_mul_int64_dotacc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_count;
`ifdef MUL_INT64_DOTACC_OVF_EN
  logic        out_ovf;
`endif

  mul_int64_dotacc #(.WIDTH(64), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MUL_INT64_DOTACC_OVF_EN
    .out_count (out_count),
    .out_ovf   (out_ovf)
`else
    .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   n_exp   = 0;
  int   n_res   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: wrapping sum, carry detection with a wider adder, saturating term count
  function automatic exp_t model(input logic [63:0] b[$]);
    exp_t        r;
    logic [64:0] s;
    r.data = '0;
    r.ovf  = 1'b0;
    foreach (b[i]) begin
      s      = {1'b0, r.data} + {1'b0, b[i]};
      r.ovf  = r.ovf | s[64];
      r.data = s[63:0];
    end
    r.cnt = (b.size() > 255) ? 8'd255 : 8'(b.size());
    return r;
  endfunction

  task automatic push_exp(input logic [63:0] b[$]);
    exp_q.push_back(model(b));
    n_exp++;
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted
  task automatic send_beat(input logic [63:0] d, input bit last, input int idle, output int waits);
    in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waits    = 0;
    while (!in_ready && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] b[$], input int max_idle);
    int w;
    push_exp(b);
    foreach (b[i]) send_beat(b[i], (i == b.size() - 1), $urandom_range(0, max_idle), w);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_out_data",  out_data,           64'd0);
    chk("rst_out_count", {56'b0, out_count}, 64'd0);
  endtask

  // Sink: drives out_ready, then scores any result handshake at the coming edge
  always @(negedge clk) begin
    exp_t e;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", {63'b0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        n_res++;
        chk("out_data", out_data, e.data);
        chk("out_count", {56'b0, out_count}, {56'b0, e.cnt});
`ifdef MUL_INT64_DOTACC_OVF_EN
        chk("out_ovf", {63'b0, out_ovf}, {63'b0, e.ovf});
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b[$];
    int          w;
    int          len;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state();

    // 3 + 5 + 7, result one cycle after last beat, gone the cycle after
    send_beat(64'd3, 1'b0, 0, w);
    send_beat(64'd5, 1'b0, 0, w);
    push_exp('{64'd7 + 64'd5 + 64'd3});
    exp_q[exp_q.size()-1].cnt = 8'd3;
    exp_q[exp_q.size()-1].ovf = 1'b0;
    send_beat(64'd7, 1'b1, 0, w);
    chk("t1_valid_next", {63'b0, out_valid}, 64'd1);
    chk("t1_data_direct", out_data, 64'd15);
    @(negedge clk);
    chk("t1_valid_drop", {63'b0, out_valid}, 64'd0);
    chk("t1_ready_back", {63'b0, in_ready}, 64'd1);
    wait_drain();

    // Single beat held with out_ready low; junk beats during the hold are ignored
    rdy_mode = 2;
    @(negedge clk);
    push_exp('{64'hDEAD});
    send_beat(64'hDEAD, 1'b1, 0, w);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", {63'b0, out_valid}, 64'd1);
      chk("t2_hold_nready", {63'b0, in_ready}, 64'd0);
      chk("t2_hold_data", out_data, 64'hDEAD);
      chk("t2_hold_count", {56'b0, out_count}, 64'd1);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rdy_mode = 0;
    wait_drain();
    chk("t2_idle_after", {63'b0, out_valid}, 64'd0);

    // Wrap with carry-out, then a clean packet clears the flag
    send_pkt('{64'hFFFF_FFFF_FFFF_FFFF, 64'd2}, 0);
    send_pkt('{64'd1, 64'd1}, 0);
    wait_drain();

    // Term count saturation
    b.delete();
    for (int i = 0; i < 300; i++) b.push_back(64'd1);
    send_pkt(b, 0);
    wait_drain();

    // Reset mid-packet discards partial sum
    send_beat(64'd10, 1'b0, 0, w);
    send_beat(64'd20, 1'b0, 0, w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state();
    send_pkt('{64'd4}, 0);
    wait_drain();

    // Back-to-back packets with in_valid held high
    push_exp('{64'd1, 64'd2});
    push_exp('{64'd3});
    push_exp('{64'd5});
    send_beat(64'd1, 1'b0, 0, w);
    chk("t6_first_nowait", 64'(w), 64'd0);
    send_beat(64'd2, 1'b1, 0, w);
    send_beat(64'd3, 1'b1, 0, w);
    chk("t6_stall_a", 64'(w), 64'd1);
    send_beat(64'd5, 1'b1, 0, w);
    chk("t6_stall_b", 64'(w), 64'd1);
    wait_drain();

    // Randomized traffic with random sink backpressure
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      b.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) b.push_back({32'hFFFF_FFFF, $urandom});
        else b.push_back({$urandom, $urandom});
      end
      send_pkt(b, 2);
    end
    rdy_mode = 0;
    wait_drain();
    chk("result_count", 64'(n_res), 64'(n_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
